// File: rtl/ascon_perm_engine.sv
// rtl/ascon_perm_engine.sv - iterative Ascon permutation, one round per clock
// Runs p12 (mode 0) or p6 (mode 1) on a 5x64 state; x0 occupies bits [319:256].
module ascon_perm_engine #(
   parameter int NB_ROUNDS_A = 12,
   parameter int NB_ROUNDS_B = 6
) (
   input  logic         clock_i,
   input  logic         resetb_i,
   input  logic         start_i,
   input  logic         mode_i,
   input  logic [319:0] state_i,
   output logic [319:0] state_o,
   output logic         busy_o,
   output logic         done_o
);

   typedef enum logic {IDLE, RUN} fsm_t;

   localparam logic [3:0] FIRST_A = 4'(12 - NB_ROUNDS_A);
   localparam logic [3:0] FIRST_B = 4'(12 - NB_ROUNDS_B);

   localparam logic [159:0] SBOX_TABLE = {
      5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
      5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
      5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
      5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
   };

   function automatic logic [63:0] ror(input logic [63:0] x, input int n);
      return (x >> n) | (x << (64 - n));
   endfunction

   function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] idx);
      logic [63:0] x [5];
      logic [63:0] y [5];
      logic [4:0]  slice_in;
      logic [4:0]  slice_out;
      int          tab_pos;
      for (int w = 0; w < 5; w++) begin
         x[w] = s[319 - 64*w -: 64];
      end
      x[2][7:0] = x[2][7:0] ^ {4'hF - idx, idx};
      for (int j = 0; j < 64; j++) begin
         slice_in  = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
         tab_pos   = int'(slice_in);
         slice_out = SBOX_TABLE[159 - 5*tab_pos -: 5];
         y[0][j]   = slice_out[4];
         y[1][j]   = slice_out[3];
         y[2][j]   = slice_out[2];
         y[3][j]   = slice_out[1];
         y[4][j]   = slice_out[0];
      end
      x[0] = y[0] ^ ror(y[0], 19) ^ ror(y[0], 28);
      x[1] = y[1] ^ ror(y[1], 61) ^ ror(y[1], 39);
      x[2] = y[2] ^ ror(y[2], 1)  ^ ror(y[2], 6);
      x[3] = y[3] ^ ror(y[3], 10) ^ ror(y[3], 17);
      x[4] = y[4] ^ ror(y[4], 7)  ^ ror(y[4], 41);
      return {x[0], x[1], x[2], x[3], x[4]};
   endfunction

   fsm_t         fsm_q, fsm_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [3:0]   rc_idx;
   logic [319:0] round_in;
   logic [319:0] round_out;
   logic [319:0] state_d;
   logic         done_d;

   assign round_out = ascon_round(round_in, rc_idx);
   assign busy_o    = (fsm_q == RUN);

   always_comb begin
      fsm_d    = fsm_q;
      cnt_d    = cnt_q;
      state_d  = state_o;
      done_d   = 1'b0;
      rc_idx   = cnt_q;
      round_in = state_o;
      case (fsm_q)
         IDLE: begin
            if (start_i) begin
               round_in = state_i;
               rc_idx   = mode_i ? FIRST_B : FIRST_A;
               state_d  = round_out;
               // A single-round permutation finishes in the start cycle itself.
               if (rc_idx == 4'd11) begin
                  cnt_d  = 4'd0;
                  done_d = 1'b1;
               end else begin
                  cnt_d = rc_idx + 4'd1;
                  fsm_d = RUN;
               end
            end
         end
         RUN: begin
            if (cnt_q > 4'd11) begin
               fsm_d = IDLE;
               cnt_d = 4'd0;
            end else begin
               state_d = round_out;
               if (cnt_q == 4'd11) begin
                  fsm_d  = IDLE;
                  cnt_d  = 4'd0;
                  done_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         default: begin
            fsm_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         fsm_q   <= IDLE;
         cnt_q   <= 4'd0;
         state_o <= '0;
         done_o  <= 1'b0;
      end else begin
         fsm_q   <= fsm_d;
         cnt_q   <= cnt_d;
         state_o <= state_d;
         done_o  <= done_d;
      end
   end

endmodule

// File: tb/tb_ascon_perm_engine.sv
// tb/tb_ascon_perm_engine.sv - randomized bench for ascon_perm_engine
// Reference uses the bitsliced boolean S-box form and computes any partial permutation from scratch.
module tb_ascon_perm_engine;

   logic         clock_i;
   logic         resetb_i;
   logic         start_i;
   logic         mode_i;
   logic [319:0] state_i;
   logic [319:0] state_o;
   logic         busy_o;
   logic         done_o;

   int n_checks = 0;
   int n_fail   = 0;
   bit check_en = 0;

   ascon_perm_engine #(.NB_ROUNDS_A(12), .NB_ROUNDS_B(6)) dut (
      .clock_i (clock_i),
      .resetb_i(resetb_i),
      .start_i (start_i),
      .mode_i  (mode_i),
      .state_i (state_i),
      .state_o (state_o),
      .busy_o  (busy_o),
      .done_o  (done_o)
   );

   initial begin
      clock_i = 1'b0;
      forever #5 clock_i = ~clock_i;
   end

   function automatic logic [63:0] m_ror(input logic [63:0] x, input int n);
      return (x >> n) | (x << (64 - n));
   endfunction

   function automatic logic [7:0] m_rc(input int i);
      return 8'(((15 - i) * 16) + i);
   endfunction

   function automatic logic [319:0] m_sbox(input logic [319:0] s);
      logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
      {x0, x1, x2, x3, x4} = s;
      x0 ^= x4; x4 ^= x3; x2 ^= x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
      x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
      return {x0, x1, x2, x3, x4};
   endfunction

   function automatic logic [319:0] m_linear(input logic [319:0] s);
      logic [63:0] x0, x1, x2, x3, x4;
      {x0, x1, x2, x3, x4} = s;
      x0 ^= m_ror(x0, 19) ^ m_ror(x0, 28);
      x1 ^= m_ror(x1, 61) ^ m_ror(x1, 39);
      x2 ^= m_ror(x2, 1)  ^ m_ror(x2, 6);
      x3 ^= m_ror(x3, 10) ^ m_ror(x3, 17);
      x4 ^= m_ror(x4, 7)  ^ m_ror(x4, 41);
      return {x0, x1, x2, x3, x4};
   endfunction

   function automatic logic [319:0] m_perm(input logic [319:0] s, input int first, input int k);
      logic [319:0] r = s;
      for (int i = 0; i < k; i++) begin
         r[135:128] ^= m_rc(first + i);
         r = m_linear(m_sbox(r));
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Model: remembers the last accepted start and derives every output from elapsed cycles.
   int           cyc = 0;
   bit           m_active;
   int           m_s, m_first, m_n;
   logic [319:0] m_in;

   always @(posedge clock_i) cyc <= cyc + 1;

   always @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         m_active <= 1'b0;
      end else if (start_i && !(m_active && (cyc - m_s) < m_n)) begin
         m_active <= 1'b1;
         m_s      <= cyc;
         m_in     <= state_i;
         m_first  <= mode_i ? 6 : 0;
         m_n      <= mode_i ? 6 : 12;
      end
   end

   always @(negedge clock_i) begin
      if (check_en) begin
         int           k;
         logic [319:0] es;
         logic         eb, ed;
         es = '0; eb = 1'b0; ed = 1'b0;
         if (m_active) begin
            k  = cyc - m_s;
            es = m_perm(m_in, m_first, (k < m_n) ? k : m_n);
            eb = (k < m_n);
            ed = (k == m_n);
         end
         check("state_o", state_o, es);
         check("busy_o", {319'b0, busy_o}, {319'b0, eb});
         check("done_o", {319'b0, done_o}, {319'b0, ed});
      end
   end

   function automatic logic [319:0] rand_state();
      logic [319:0] r;
      for (int i = 0; i < 10; i++) r[32*i +: 32] = $urandom();
      return r;
   endfunction

   task automatic launch(input logic mode, input logic [319:0] st);
      start_i = 1'b1;
      mode_i  = mode;
      state_i = st;
      @(posedge clock_i);
      #1 start_i = 1'b0;
      state_i = rand_state();
   endtask

   task automatic measure(output int lat, output int busy_cycles);
      lat = 1;
      busy_cycles = busy_o ? 1 : 0;
      while (!done_o && lat < 40) begin
         @(posedge clock_i);
         #1 lat++;
         if (busy_o) busy_cycles++;
      end
   endtask

   int lat, bc, dones;

   initial begin
      resetb_i = 1'b1;
      start_i  = 1'b0;
      mode_i   = 1'b0;
      state_i  = '0;
      #2 resetb_i = 1'b0;
      #1;
      check("reset_state", state_o, '0);
      check("reset_busy", {319'b0, busy_o}, '0);
      check("reset_done", {319'b0, done_o}, '0);
      check_en = 1;
      repeat (2) @(posedge clock_i);
      #1 resetb_i = 1'b1;
      repeat (5) @(posedge clock_i);
      #1;

      check("pin_rc0", {312'b0, m_rc(0)}, {312'b0, 8'hF0});
      check("pin_rc11", {312'b0, m_rc(11)}, {312'b0, 8'h4B});
      check("pin_sbox0", m_sbox('0), {64'h0, 64'h0, ~64'h0, 64'h0, 64'h0});
      check("pin_sbox1", m_sbox({256'h0, 64'h1}),
            {64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1, 64'h1});
      check("pin_linear", m_linear({64'h1, 256'h0}), {64'h0000_2010_0000_0001, 256'h0});

      launch(1'b0, {64'h80400C0600000000, 256'h0});
      measure(lat, bc);
      check("pa_latency", 320'(lat), 320'd12);
      check("pa_busy_cycles", 320'(bc), 320'd11);
      @(posedge clock_i); #1;

      launch(1'b1, rand_state());
      measure(lat, bc);
      check("pb_latency", 320'(lat), 320'd6);
      @(posedge clock_i); #1;

      launch(1'b0, rand_state());
      repeat (2) @(posedge clock_i);
      #1 start_i = 1'b1;
      mode_i  = 1'b1;
      state_i = rand_state();
      @(posedge clock_i);
      #1 start_i = 1'b0;
      measure(lat, bc);
      check("start_in_run_latency", 320'(lat + 3), 320'd12);

      launch(1'b1, rand_state());
      measure(lat, bc);
      launch(1'b1, rand_state());
      measure(lat, bc);
      check("back_to_back_latency", 320'(lat), 320'd6);
      @(posedge clock_i); #1;

      launch(1'b0, rand_state());
      repeat (4) @(posedge clock_i);
      #2 resetb_i = 1'b0;
      #1;
      check("abort_state", state_o, '0);
      check("abort_busy", {319'b0, busy_o}, '0);
      check("abort_done", {319'b0, done_o}, '0);
      repeat (2) @(posedge clock_i);
      #1 resetb_i = 1'b1;
      dones = 0;
      repeat (15) begin
         @(posedge clock_i);
         #1 if (done_o) dones++;
      end
      check("abort_no_done", 320'(dones), 320'd0);
      launch(1'b1, rand_state());
      measure(lat, bc);
      check("after_abort_latency", 320'(lat), 320'd6);
      @(posedge clock_i); #1;

      for (int r = 0; r < 8; r++) begin
         logic m;
         m = 1'($urandom_range(0, 1));
         launch(m, rand_state());
         measure(lat, bc);
         check("rand_latency", 320'(lat), m ? 320'd6 : 320'd12);
         repeat ($urandom_range(0, 2)) @(posedge clock_i);
         #1;
      end

      repeat (3) @(posedge clock_i);
      #1 check_en = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
